fetch_ir_unit: RTL

Program-counter and instruction-register stage directly upstream of the multi-cycle main decoder. It holds PC, OldPC and IR, and feeds opcode/funct3 and the extended immediate into the decoder and datapath. It applies the decoder's PCUpdate and branch strobes against the ALU flags. It also keeps cycle/retired-instruction counters and sticky illegal-instruction and misaligned-PC flags.

---
 rtl/fetch_ir_unit_if.sv | 54 +++++
 rtl/fetch_ir_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_ir_unit_if.sv
// Purpose: bundles the decoder/datapath-facing signals of the PC/IR stage.
// Latency: none, this is wiring only.
// Backpressure: none, these are strobe-driven signals with no handshake.
interface fetch_ir_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  instr_rdata;
  logic [XLEN-1:0]  pc_next;
  logic             irwrite;
  logic             pcupdate;
  logic             beq;
  logic             bne;
  logic             blt;
  logic             bge;
  logic             alu_zero;
  logic             alu_lt;
  logic             regwrite;
  logic             memwrite;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  old_pc;
  logic [XLEN-1:0]  instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm_ext;
  logic             branch_taken;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;
  logic             illegal_instr;
  logic [XLEN-1:0]  illegal_pc;
  logic             misaligned_pc;

  // Decoder/memory/datapath side.
  modport master (
    output instr_rdata, pc_next, irwrite, pcupdate, beq, bne, blt, bge,
           alu_zero, alu_lt, regwrite, memwrite,
    input  pc, old_pc, instr, opcode, funct3, funct7b5, rs1, rs2, rd,
           imm_ext, branch_taken, cycle_count, instret_count,
           illegal_instr, illegal_pc, misaligned_pc
  );

  // PC/IR stage side.
  modport slave (
    input  instr_rdata, pc_next, irwrite, pcupdate, beq, bne, blt, bge,
           alu_zero, alu_lt, regwrite, memwrite,
    output pc, old_pc, instr, opcode, funct3, funct7b5, rs1, rs2, rd,
           imm_ext, branch_taken, cycle_count, instret_count,
           illegal_instr, illegal_pc, misaligned_pc
  );
endinterface

// File: rtl/fetch_ir_unit.sv
// Purpose: PC / OldPC / IR stage with immediate extension, branch resolve, counters and sticky fault flags.
// Latency: PC/IR update on the strobed edge; decoded fields and branch_taken are combinational; legality flag lands one cycle after IR capture.
// Backpressure: none, the multi-cycle decoder sequences every strobe so this stage never stalls.
module fetch_ir_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic           clk,
  input logic           reset,
  fetch_ir_unit_if.slave bus
);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  old_pc_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  illegal_pc_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic             ir_new;
  logic             illegal_q;
  logic             misaligned_q;
  logic             branch_taken;
  logic             pc_we;
  logic             retire;
  logic             legal;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [31:0]      imm32;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];

  // Resolve the decoder's branch strobe against the ALU flags.
  always_comb begin
    branch_taken = (bus.beq & bus.alu_zero) | (bus.bne & ~bus.alu_zero) |
                   (bus.blt & bus.alu_lt)   | (bus.bge & ~bus.alu_lt);
  end

  assign pc_we  = bus.pcupdate | branch_taken;
  // Each of these strobes marks the single completion cycle of an instruction.
  assign retire = bus.regwrite | bus.memwrite | bus.beq | bus.bne | bus.blt | bus.bge;

  // Reassemble the immediate according to the instruction format implied by the opcode.
  always_comb begin
    imm32 = '0;
    case (opcode)
      7'b0000011, 7'b0010011: imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      7'b0100011:             imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      7'b1100011:             imm32 = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                                       instr_q[11:8], 1'b0};
      7'b1101111:             imm32 = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                                       instr_q[30:21], 1'b0};
      7'b0110111:             imm32 = {instr_q[31:12], 12'b0};
      default:                imm32 = '0;
    endcase
  end

  // Only the opcodes the decoder supports are legal; branches also restrict funct3.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1101111, 7'b0110111: legal = 1'b1;
      7'b1100011:             legal = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      default:                legal = 1'b0;
    endcase
  end

  // PC, IR and sticky fault flags; IR/old_pc capture the pre-update PC when fetch also bumps PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      ir_new       <= 1'b0;
      illegal_q    <= 1'b0;
      illegal_pc_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      ir_new <= bus.irwrite;
      if (bus.irwrite) begin
        instr_q  <= bus.instr_rdata;
        old_pc_q <= pc_q;
      end
      if (pc_we) begin
        pc_q <= bus.pc_next;
        if (bus.pc_next[1:0] != 2'b00) begin
          misaligned_q <= 1'b1;
        end
      end
      if (ir_new && !legal && !illegal_q) begin
        illegal_q    <= 1'b1;
        illegal_pc_q <= old_pc_q;
      end
    end
  end

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + CNT_W'(1);
      instret_q <= instret_q + CNT_W'(retire);
    end
  end

  assign bus.pc            = pc_q;
  assign bus.old_pc        = old_pc_q;
  assign bus.instr         = instr_q;
  assign bus.opcode        = opcode;
  assign bus.funct3        = funct3;
  assign bus.funct7b5      = instr_q[30];
  assign bus.rs1           = instr_q[19:15];
  assign bus.rs2           = instr_q[24:20];
  assign bus.rd            = instr_q[11:7];
  assign bus.imm_ext       = XLEN'($signed(imm32));
  assign bus.branch_taken  = branch_taken;
  assign bus.cycle_count   = cycle_q;
  assign bus.instret_count = instret_q;
  assign bus.illegal_instr = illegal_q;
  assign bus.illegal_pc    = illegal_pc_q;
  assign bus.misaligned_pc = misaligned_q;

endmodule
